// File: rtl/gamma_coef_sequencer_pkg.sv
// Shared types and defaults for the gamma coefficient sequencer.
package gamma_pkg;

  localparam int COEF_W = 10;

  typedef logic [COEF_W-1:0] coef_t;

  localparam coef_t P1_DEF = 10'h0FF;
  localparam coef_t P2_DEF = 10'h300;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;

endpackage

// File: rtl/gamma_coef_sequencer_if.sv
// Request/acknowledge and live-coefficient bundle between the control requester and the sequencer.
interface gamma_coef_sequencer_if;
  import gamma_pkg::*;

  logic  REQ;
  coef_t TGT_P1;
  coef_t TGT_P2;
  logic  ACK;
  coef_t COEF_P1;
  coef_t COEF_P2;
  logic  BUSY;
  logic  DONE;

  modport master (
    output REQ, TGT_P1, TGT_P2,
    input  ACK, COEF_P1, COEF_P2, BUSY, DONE
  );

  modport slave (
    input  REQ, TGT_P1, TGT_P2,
    output ACK, COEF_P1, COEF_P2, BUSY, DONE
  );

endinterface

// File: rtl/gamma_coef_sequencer_coef_stepper.sv
// Moves one coefficient toward its target by at most step_i; step_i of zero jumps straight to the target.
module coef_stepper
  import gamma_pkg::*;
(
  input  coef_t cur_i,
  input  coef_t tgt_i,
  input  coef_t step_i,
  output coef_t nxt_o
);

  logic [COEF_W:0] diff_s;

  // Clamp the step to the remaining distance so the result never overshoots or wraps.
  always_comb begin
    diff_s = {(COEF_W+1){1'b0}};
    nxt_o  = cur_i;
    if (tgt_i > cur_i) begin
      diff_s = {1'b0, tgt_i} - {1'b0, cur_i};
      if ((step_i == coef_t'(0)) || (diff_s <= {1'b0, step_i})) begin
        nxt_o = tgt_i;
      end else begin
        nxt_o = cur_i + step_i;
      end
    end else if (tgt_i < cur_i) begin
      diff_s = {1'b0, cur_i} - {1'b0, tgt_i};
      if ((step_i == coef_t'(0)) || (diff_s <= {1'b0, step_i})) begin
        nxt_o = tgt_i;
      end else begin
        nxt_o = cur_i - step_i;
      end
    end else begin
      nxt_o = cur_i;
    end
  end

endmodule

// File: rtl/gamma_coef_sequencer.sv
// Frame-synchronous sequencer that ramps the shared Bezier P1/P2 gamma coefficients toward a requested target.
module gamma_coef_sequencer
  import gamma_pkg::*;
#(
  parameter coef_t P1_INIT = P1_DEF,
  parameter coef_t P2_INIT = P2_DEF,
  parameter int    STEP    = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    VS,
  gamma_coef_sequencer_if.slave   bus
);

  localparam coef_t STEP_C = coef_t'(STEP);

  state_e state_q, state_d;
  coef_t  p1_q, p1_d, p2_q, p2_d;
  coef_t  t1_q, t1_d, t2_q, t2_d;
  logic   ack_q, ack_d;
  logic   done_q, done_d;
  logic   busy_q, busy_d;
  logic   vs_q;
  logic   vs_rise_s, accept_s, step_en_s;
  coef_t  p1_nxt_s, p2_nxt_s;

  coef_stepper u_step_p1 (.cur_i(p1_q), .tgt_i(t1_q), .step_i(STEP_C), .nxt_o(p1_nxt_s));
  coef_stepper u_step_p2 (.cur_i(p2_q), .tgt_i(t2_q), .step_i(STEP_C), .nxt_o(p2_nxt_s));

  assign vs_rise_s = VS & ~vs_q;
  assign accept_s  = bus.REQ & ~ack_q;
  assign step_en_s = (state_q == RAMP) & vs_rise_s;

  // The step always uses the target latched before this cycle; a target accepted now applies from the next frame.
  always_comb begin
    p1_d    = p1_q;
    p2_d    = p2_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    done_d  = 1'b0;
    ack_d   = accept_s;
    state_d = state_q;
    if (step_en_s) begin
      p1_d   = p1_nxt_s;
      p2_d   = p2_nxt_s;
      done_d = (p1_nxt_s == t1_q) && (p2_nxt_s == t2_q);
    end else begin
      done_d = 1'b0;
    end
    if (accept_s) begin
      t1_d = bus.TGT_P1;
      t2_d = bus.TGT_P2;
    end else begin
      t1_d = t1_q;
      t2_d = t2_q;
    end
    if ((p1_d != t1_d) || (p2_d != t2_d)) begin
      state_d = RAMP;
    end else begin
      state_d = IDLE;
    end
    busy_d = (state_d == RAMP);
  end

  // State and output registers; reset discards any pending target or ramp.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      p1_q    <= P1_INIT;
      p2_q    <= P2_INIT;
      t1_q    <= P1_INIT;
      t2_q    <= P2_INIT;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      vs_q    <= VS;
    end
  end

  assign bus.ACK     = ack_q;
  assign bus.DONE    = done_q;
  assign bus.BUSY    = busy_q;
  assign bus.COEF_P1 = p1_q;
  assign bus.COEF_P2 = p2_q;

endmodule

// File: tb/tb_gamma_coef_sequencer.sv
// Scoreboard bench: two sequencers (STEP=16 and STEP=0) share stimulus; a frame-level reference model predicts every output event.
module tb_gamma_coef_sequencer;
  import gamma_pkg::*;

  logic CLK = 1'b0;
  logic RESET_N = 1'b1;
  logic VS = 1'b0;
  logic mon_en = 1'b0;

  gamma_coef_sequencer_if ifa ();
  gamma_coef_sequencer_if ifb ();

  gamma_coef_sequencer #(.P1_INIT(10'h0FF), .P2_INIT(10'h300), .STEP(16)) dut16 (
    .CLK(CLK), .RESET_N(RESET_N), .VS(VS), .bus(ifa.slave));
  gamma_coef_sequencer #(.P1_INIT(10'h0FF), .P2_INIT(10'h300), .STEP(0)) dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .VS(VS), .bus(ifb.slave));

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    int         dut;
    logic       ack;
    logic       done;
    logic       busy;
    logic [9:0] p1;
    logic [9:0] p2;
  } ev_t;

  ev_t sbq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  // reference model state: live values, targets, ramp flag per instance
  logic [9:0] m_l[2][2];
  logic [9:0] m_t[2][2];
  logic       m_busy[2];
  logic       m_ack;
  logic       m_vs;
  int         m_step[2];

  logic       o_ack[2], o_done[2], o_busy[2];
  logic [9:0] o_p1[2], o_p2[2];
  logic       pv_busy[2];
  logic [9:0] pv_p1[2], pv_p2[2];

  assign o_ack[0] = ifa.ACK;      assign o_ack[1] = ifb.ACK;
  assign o_done[0] = ifa.DONE;    assign o_done[1] = ifb.DONE;
  assign o_busy[0] = ifa.BUSY;    assign o_busy[1] = ifb.BUSY;
  assign o_p1[0] = ifa.COEF_P1;   assign o_p1[1] = ifb.COEF_P1;
  assign o_p2[0] = ifa.COEF_P2;   assign o_p2[1] = ifb.COEF_P2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] mv(input logic [9:0] c, input logic [9:0] t, input int step);
    int diff;
    int mag;
    diff = int'(t) - int'(c);
    mag  = (diff < 0) ? -diff : diff;
    if (step == 0 || mag <= step) return t;
    return (diff > 0) ? 10'(int'(c) + step) : 10'(int'(c) - step);
  endfunction

  task automatic model_reset();
    m_step[0] = 16;
    m_step[1] = 0;
    for (int d = 0; d < 2; d++) begin
      m_l[d][0] = 10'h0FF; m_l[d][1] = 10'h300;
      m_t[d][0] = 10'h0FF; m_t[d][1] = 10'h300;
      m_busy[d] = 1'b0;
    end
    m_ack = 1'b0;
    m_vs  = 1'b0;
  endtask

  task automatic drive_tgt(input logic [9:0] t1, input logic [9:0] t2);
    ifa.TGT_P1 = t1; ifa.TGT_P2 = t2;
    ifb.TGT_P1 = t1; ifb.TGT_P2 = t2;
  endtask

  // drive one cycle of inputs at the falling edge and predict what the next rising edge produces
  task automatic tick(input logic vs, input logic req);
    logic acc, vr, dn, nb;
    logic [9:0] n1, n2;
    ev_t e;
    VS = vs; ifa.REQ = req; ifb.REQ = req;
    acc = req && !m_ack;
    vr  = vs && !m_vs;
    for (int d = 0; d < 2; d++) begin
      n1 = m_l[d][0]; n2 = m_l[d][1]; dn = 1'b0;
      if (m_busy[d] && vr) begin
        n1 = mv(m_l[d][0], m_t[d][0], m_step[d]);
        n2 = mv(m_l[d][1], m_t[d][1], m_step[d]);
        dn = (n1 == m_t[d][0]) && (n2 == m_t[d][1]);
      end
      if (acc) begin
        m_t[d][0] = ifa.TGT_P1; m_t[d][1] = ifa.TGT_P2;
      end
      nb = (n1 != m_t[d][0]) || (n2 != m_t[d][1]);
      if (acc || dn || nb != m_busy[d] || n1 != m_l[d][0] || n2 != m_l[d][1]) begin
        e.cyc = cyc + 1; e.dut = d; e.ack = acc; e.done = dn; e.busy = nb; e.p1 = n1; e.p2 = n2;
        sbq.push_back(e);
      end
      m_l[d][0] = n1; m_l[d][1] = n2; m_busy[d] = nb;
    end
    m_ack = acc;
    m_vs  = vs;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("rst_p1_a", 32'(ifa.COEF_P1), 32'h0FF);
    chk("rst_p2_a", 32'(ifa.COEF_P2), 32'h300);
    chk("rst_p1_b", 32'(ifb.COEF_P1), 32'h0FF);
    chk("rst_flags_a", {29'd0, ifa.BUSY, ifa.ACK, ifa.DONE}, 32'h0);
    chk("rst_flags_b", {29'd0, ifb.BUSY, ifb.ACK, ifb.DONE}, 32'h0);
    sbq.delete();
    model_reset();
    VS = 1'b0; ifa.REQ = 1'b0; ifb.REQ = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    mon_en = 1'b1;
  endtask

  // monitor: every cycle with an output event must match the head of the scoreboard
  always @(posedge CLK) begin
    #1;
    cyc++;
    if (!RESET_N || !mon_en) begin
      for (int d = 0; d < 2; d++) begin
        pv_busy[d] = 1'b0; pv_p1[d] = 10'h0FF; pv_p2[d] = 10'h300;
      end
    end else begin
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL stale_event dut%0d cyc %0d", sbq[0].dut, sbq[0].cyc);
        void'(sbq.pop_front());
      end
      for (int d = 0; d < 2; d++) begin
        logic obs, here;
        ev_t e;
        obs  = o_ack[d] || o_done[d] || (o_busy[d] !== pv_busy[d]) ||
               (o_p1[d] !== pv_p1[d]) || (o_p2[d] !== pv_p2[d]);
        here = sbq.size() > 0 && sbq[0].cyc == cyc && sbq[0].dut == d;
        if (obs && here) begin
          e = sbq.pop_front();
          checks++;
          if (o_ack[d] !== e.ack || o_done[d] !== e.done || o_busy[d] !== e.busy ||
              o_p1[d] !== e.p1 || o_p2[d] !== e.p2) begin
            errors++;
            $display("FAIL event dut%0d cyc %0d got ack%b done%b busy%b p1=%h p2=%h want ack%b done%b busy%b p1=%h p2=%h",
                     d, cyc, o_ack[d], o_done[d], o_busy[d], o_p1[d], o_p2[d],
                     e.ack, e.done, e.busy, e.p1, e.p2);
          end
        end else if (obs) begin
          checks++; errors++;
          $display("FAIL unexpected dut%0d cyc %0d got ack%b done%b busy%b p1=%h p2=%h want no change",
                   d, cyc, o_ack[d], o_done[d], o_busy[d], o_p1[d], o_p2[d]);
        end else if (here) begin
          e = sbq.pop_front();
          checks++; errors++;
          $display("FAIL missing dut%0d cyc %0d got no change want ack%b done%b busy%b p1=%h p2=%h",
                   d, cyc, e.ack, e.done, e.busy, e.p1, e.p2);
        end
        pv_busy[d] = o_busy[d]; pv_p1[d] = o_p1[d]; pv_p2[d] = o_p2[d];
      end
    end
  end

  initial begin
    logic lastreq;
    logic vsr, reqr;
    int   v1, v2;
    ifa.REQ = 1'b0; ifb.REQ = 1'b0;
    drive_tgt(10'h0FF, 10'h300);
    model_reset();
    do_reset();

    // basic ascending ramp, and STEP=0 jumping in one frame
    drive_tgt(10'h11F, 10'h300);
    tick(1'b0, 1'b1);
    chk("ack_a", 32'(ifa.ACK), 32'h1);
    chk("busy_on_ack", 32'(ifa.BUSY), 32'h1);
    tick(1'b0, 1'b0);
    chk("ack_pulse", 32'(ifa.ACK), 32'h0);
    tick(1'b1, 1'b0);
    chk("frame1_p1", 32'(ifa.COEF_P1), 32'h10F);
    chk("frame1_done", 32'(ifa.DONE), 32'h0);
    chk("jump_p1_b", 32'(ifb.COEF_P1), 32'h11F);
    chk("jump_done_b", 32'(ifb.DONE), 32'h1);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("frame2_p1", 32'(ifa.COEF_P1), 32'h11F);
    chk("frame2_done", 32'(ifa.DONE), 32'h1);
    chk("p2_static", 32'(ifa.COEF_P2), 32'h300);
    tick(1'b0, 1'b0);
    chk("busy_off", 32'(ifa.BUSY), 32'h0);

    // descending by less than one step clamps at the target
    drive_tgt(10'h11F, 10'h2F5);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("desc_p2", 32'(ifa.COEF_P2), 32'h2F5);
    chk("desc_done", 32'(ifa.DONE), 32'h1);
    tick(1'b0, 1'b0);

    // no-op request
    tick(1'b0, 1'b1);
    chk("noop_ack", 32'(ifa.ACK), 32'h1);
    chk("noop_busy", 32'(ifa.BUSY), 32'h0);
    tick(1'b0, 1'b0);

    // STEP=0 holds until the frame edge, then lands on the extremes
    drive_tgt(10'h000, 10'h3FF);
    tick(1'b0, 1'b1);
    repeat (6) tick(1'b0, 1'b0);
    chk("jump_hold_b", 32'(ifb.COEF_P1), 32'h11F);
    tick(1'b1, 1'b0);
    chk("jump_p1_0", 32'(ifb.COEF_P1), 32'h000);
    chk("jump_p2_3ff", 32'(ifb.COEF_P2), 32'h3FF);
    repeat (1000) tick(1'b0, 1'b0);
    chk("gate_hold", 32'(ifa.COEF_P1), 32'h10F);
    do_reset();

    // retarget mid-ramp
    drive_tgt(10'h1FF, 10'h300);
    tick(1'b0, 1'b1); tick(1'b0, 1'b0);
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    chk("rt_live", 32'(ifa.COEF_P1), 32'h11F);
    drive_tgt(10'h0FF, 10'h300);
    tick(1'b0, 1'b1); tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("rt_f1", 32'(ifa.COEF_P1), 32'h10F);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("rt_f2", 32'(ifa.COEF_P1), 32'h0FF);
    chk("rt_done", 32'(ifa.DONE), 32'h1);
    tick(1'b0, 1'b0);

    // request coincident with a frame edge steps toward the old target
    drive_tgt(10'h1FF, 10'h300);
    tick(1'b0, 1'b1); tick(1'b0, 1'b0);
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    drive_tgt(10'h0FF, 10'h300);
    tick(1'b1, 1'b1);
    chk("sim_old_tgt", 32'(ifa.COEF_P1), 32'h11F);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("sim_new_tgt", 32'(ifa.COEF_P1), 32'h10F);
    tick(1'b0, 1'b0);

    // randomized traffic against the model
    lastreq = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      vsr  = ($urandom_range(0, 2) == 0);
      reqr = !lastreq && ($urandom_range(0, 5) == 0);
      if (reqr) begin
        case ($urandom_range(0, 2))
          0: begin v1 = $urandom_range(0, 1023); v2 = $urandom_range(0, 1023); end
          1: begin
            v1 = int'(m_l[0][0]) + $urandom_range(0, 80) - 40;
            v2 = int'(m_l[0][1]) + $urandom_range(0, 80) - 40;
          end
          default: begin v1 = int'(m_l[0][0]); v2 = int'(m_l[0][1]); end
        endcase
        v1 = (v1 < 0) ? 0 : ((v1 > 1023) ? 1023 : v1);
        v2 = (v2 < 0) ? 0 : ((v2 > 1023) ? 1023 : v2);
        drive_tgt(10'(v1), 10'(v2));
      end
      tick(vsr, reqr);
      lastreq = reqr;
      if (i == 700) do_reset();
    end
    repeat (5) tick(1'b0, 1'b0);
    chk("sb_drained", 32'(sbq.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gamma_coef_sequencer.md
Name: gamma_coef_sequencer

Overview:
- Owns the two 10-bit Bezier control-point coefficients (P1, P2) shared by the three per-channel gamma curves.
- Accepts new target coefficients from a control requester via a REQ/ACK handshake.
- Changes the live coefficients only at frame boundaries (VS rising edge), so no frame is ever split between two curves.
- Moves the live coefficients toward the target by a bounded step per frame, giving a visually smooth gamma transition.

Parameters:
- P1_INIT, 10'h0FF, reset/default value of COEF_P1.
- P2_INIT, 10'h300, reset/default value of COEF_P2.
- STEP, 16, maximum change per coefficient per frame. 0 means jump directly to the target at the next frame boundary. Legal range 0..1023.

Ports:
- CLK  in  1  pixel clock; all logic on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- VS  in  1  vertical sync, synchronous to CLK, active high. A rising edge marks a frame boundary.
- REQ  in  1  target-update request; held high until ACK.
- TGT_P1  in  10  requested P1 target; sampled when the request is accepted.
- TGT_P2  in  10  requested P2 target; sampled when the request is accepted.
- ACK  out  1  one-cycle pulse: request accepted, targets latched.
- COEF_P1  out  10  live P1 coefficient to the curve datapath; registered.
- COEF_P2  out  10  live P2 coefficient to the curve datapath; registered.
- BUSY  out  1  high while live coefficients differ from latched targets.
- DONE  out  1  one-cycle pulse when a ramp completes.

Behaviour:
- Reset (async, RESET_N=0):
  - COEF_P1=P1_INIT, COEF_P2=P2_INIT.
  - Internal targets equal the INIT values.
  - ACK=0, BUSY=0, DONE=0, state IDLE.
  - VS edge-detect register cleared to 0, so VS already high at reset release counts as one edge.
- Reset mid-ramp discards both the target and the ramp. No ACK or DONE is issued for a request pending at reset.
- VS edge detect: vs_q registers VS. vs_rise = VS & ~vs_q. Latency of one CLK from the VS edge to the coefficient update.
- Handshake:
  - A request is accepted in any cycle where REQ=1 and ACK is not already asserted. Acceptance is allowed in IDLE and in RAMP.
  - On acceptance, TGT_P1/TGT_P2 are latched and ACK pulses high for exactly the next cycle.
  - The requester must deassert REQ during the ACK cycle. REQ still high the cycle after ACK is a new request.
  - REQ/TGT are ignored while ACK=1.
- State machine:
  - IDLE:
    - Accepted targets equal to the live coefficients: stay IDLE, ACK only, no DONE.
    - Accepted targets that differ: go to RAMP, and BUSY=1 from the ACK cycle.
  - RAMP, on each vs_rise, for each coefficient independently:
    - If live < target: live += min(STEP, target−live).
    - If live > target: live −= min(STEP, live−target).
    - STEP=0: live = target.
    - Arithmetic uses 11-bit unsigned differences. The result never overshoots and never wraps outside 0..1023.
    - After the update, if both coefficients equal their targets: go to IDLE, BUSY=0, and DONE pulses one cycle (the cycle after vs_rise).
  - RAMP, without vs_rise: coefficients are held.
- Retarget in RAMP: a newly accepted target replaces the old one. The ramp continues from the current live values. BUSY stays high.
- Simultaneous vs_rise and acceptance in the same cycle:
  - The step uses the previously latched target.
  - The new target takes effect from the next vs_rise.
  - If the step reaches the old target, DONE still pulses, and the state goes RAMP again if the new target differs from the live values.
- COEF_P1/COEF_P2 never change except in the cycle after a vs_rise, or on reset.
- DONE and ACK may be high in the same cycle.

Decomposition:
- Shared package (gamma_pkg):
  - COEF_W=10.
  - Default coefficients P1_DEF=10'h0FF and P2_DEF=10'h300.
  - State enum {IDLE, RAMP}.
- One natural sub-module, coef_stepper: a combinational "move cur toward tgt by at most STEP" function with width COEF_W and a STEP input. It is instantiated twice, once per coefficient.

Test Plan:
- Reset: assert RESET_N=0 mid-clock → COEF_P1=0x0FF and COEF_P2=0x300 immediately. BUSY, ACK, DONE = 0.
- Basic ramp, STEP=16: request P1=0x11F, P2=0x300 → ACK one cycle, BUSY=1. P1 takes 0x10F after frame 1 and 0x11F after frame 2. DONE pulses after frame 2, then BUSY=0. P2 stays 0x300 throughout.
- Non-multiple step, descending: request P2=0x2F5 from 0x300 with STEP=16 → P2 goes 0x2F5 in a single frame (clamped, no undershoot). DONE after that frame.
- STEP=0 jump: request P1=0x000, P2=0x3FF → both live values equal the targets one cycle after the next vs_rise. No change happens before that vs_rise.
- Retarget mid-ramp: during a ramp toward 0x1FF from 0x0FF (live 0x11F), request 0x0FF → ACK. The next frame gives 0x10F, the following frame 0x0FF, then DONE. Also issue REQ in the same cycle as vs_rise and check the step used the old target.
- No-op and frame gating: request targets equal to live → ACK only, no DONE, BUSY stays 0. Hold VS low for 1000 cycles during a RAMP → coefficients are unchanged.
